video_fetch_sequencer: RTL and testbench

Bus-master controller that sequences pixel data from RAM into the display path, once per frame, at the pixel rate the display consumes it. It sits between the CPU bus arbiter and the 640x480 VGA/HDMI output stage. It issues burst reads from a framebuffer base address and buffers the returned words in an internal FIFO. It presents the head word as four 8-pixel byte planes (red, green, blue, bright) and pops on each `rd` pulse from the display. Frame alignment comes from the display's vsync.

---
 rtl/video_fetch_sequencer.sv | 246 ++++++++++++++++++++++++
 tb/tb_video_fetch_sequencer.sv | 299 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/video_fetch_sequencer.sv
// video_fetch_sequencer
//
// Bus-master fetch engine for the 640x480 display path. Once per frame, on a
// falling edge of the display vsync, it reads FRAME_WORDS words starting at
// base_addr in bursts of up to BURST_LEN words. The words go into an internal
// FIFO whose head is presented as four 8-pixel byte planes. The display pops
// the head with a one-clock rd pulse.
//
// Optional feature (macro VIDEO_FETCH_UNDERRUN_CNT_EN):
//   defined   -> extra output underrun_cnt[15:0], a saturating count of pops
//                seen while the FIFO was empty. Cleared only by reset.
//   undefined -> no counter and no port; only the sticky underrun flag exists.
//
// Handshake: while bus_strobe is high, bus_addr is the word being requested.
// Each cycle in which bus_strobe and bus_ack are both high transfers bus_data
// for that address. bus_strobe never drops before the burst's last ack, and
// bus_addr only moves in the cycle after an ack.
//
// Ports
//   clk, reset        bus clock; synchronous active-high reset
//   enable            fetching allowed, sampled at each frame start
//   base_addr         framebuffer word address, sampled at frame start
//   vga_vsync         active-low vsync from the pixel clock domain
//   rd                one-clock pop pulse from the display
//   bus_addr          read word address
//   bus_strobe        read request
//   bus_ack           word returned this cycle
//   bus_data          read data: byte0 red, byte1 green, byte2 blue, byte3 bright
//   red_byte..bright_byte  registered copy of the FIFO head word
//   underrun          sticky; set by a pop on empty, cleared at frame start
//   dbg_state         current FSM state (IDLE=0 ARM=1 FETCH=2 WAIT=3 DONE=4)
//   dbg_level         current FIFO occupancy
module video_fetch_sequencer #(
  parameter int ADDR_BITS   = 30,
  parameter int FIFO_LOG2   = 5,
  parameter int BURST_LEN   = 8,
  parameter int FRAME_WORDS = 38400
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 enable,
  input  logic [ADDR_BITS-1:0] base_addr,
  input  logic                 vga_vsync,
  input  logic                 rd,
  output logic [ADDR_BITS-1:0] bus_addr,
  output logic                 bus_strobe,
  input  logic                 bus_ack,
  input  logic [31:0]          bus_data,
  output logic [7:0]           red_byte,
  output logic [7:0]           green_byte,
  output logic [7:0]           blue_byte,
  output logic [7:0]           bright_byte,
  output logic                 underrun,
`ifdef VIDEO_FETCH_UNDERRUN_CNT_EN
  output logic [15:0]          underrun_cnt,
`endif
  output logic [2:0]           dbg_state,
  output logic [FIFO_LOG2:0]   dbg_level
);

  localparam int DEPTH = 1 << FIFO_LOG2;
  localparam int PW    = FIFO_LOG2 + 1;
  localparam int WL_W  = $clog2(FRAME_WORDS + 1);
  localparam int FIRST_BURST = (FRAME_WORDS < BURST_LEN) ? FRAME_WORDS : BURST_LEN;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ARM   = 3'd1,
    S_FETCH = 3'd2,
    S_WAIT  = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t state, state_n;

  // ---------------------------------------------------------------------------
  // vsync: two-flop synchronizer, then an edge register for the fall detect.
  // Reset values assume vsync idles high so reset cannot fake an edge.
  // ---------------------------------------------------------------------------
  logic vs_meta, vs_sync, vs_prev;
  logic vs_fall;
  logic frame_pending;
  logic pending_take;

  assign vs_fall = vs_prev & ~vs_sync;

  always_ff @(posedge clk) begin
    if (reset) begin
      vs_meta       <= 1'b1;
      vs_sync       <= 1'b1;
      vs_prev       <= 1'b1;
      frame_pending <= 1'b0;
    end else begin
      vs_meta       <= vga_vsync;
      vs_sync       <= vs_meta;
      vs_prev       <= vs_sync;
      // A new edge in the same cycle as a take re-arms the request.
      frame_pending <= vs_fall | (frame_pending & ~pending_take);
    end
  end

  // ---------------------------------------------------------------------------
  // FIFO bookkeeping. Pointers carry one extra bit so full and empty differ.
  // ---------------------------------------------------------------------------
  logic [31:0]          mem [DEPTH];
  logic [PW-1:0]        wr_ptr, rd_ptr, level, free_slots;
  logic                 fifo_empty, fifo_full;
  logic                 wr_en, pop, empty_pop, rd_live;
  logic [ADDR_BITS-1:0] addr;
  logic [WL_W-1:0]      words_left;
  logic [PW-1:0]        burst_cnt;
  logic [31:0]          wl32, need32;
  logic                 space_ok, load_burst;
  logic [31:0]          out_word;

  assign level      = wr_ptr - rd_ptr;
  assign free_slots = PW'(DEPTH) - level;
  assign fifo_empty = (level == '0);
  assign fifo_full  = (level == PW'(DEPTH));

  assign wr_en     = (state == S_FETCH) && bus_ack;
  // The flush in ARM takes priority, so a pop in that cycle is dropped.
  assign rd_live   = rd && (state != S_ARM);
  assign pop       = rd_live && !fifo_empty;
  assign empty_pop = rd_live && fifo_empty;

  // Next burst is min(BURST_LEN, words_left). It starts only when the whole
  // burst fits, so a write can never land on a full FIFO.
  assign wl32     = 32'(words_left);
  assign need32   = (wl32 < 32'(BURST_LEN)) ? wl32 : 32'(BURST_LEN);
  assign space_ok = (32'(free_slots) >= need32);

  // ---------------------------------------------------------------------------
  // FSM next state
  // ---------------------------------------------------------------------------
  always_comb begin
    state_n      = state;
    pending_take = 1'b0;
    load_burst   = 1'b0;
    case (state)
      S_IDLE: begin
        if (frame_pending) begin
          pending_take = 1'b1;
          if (enable) state_n = S_ARM;
        end
      end
      // The buffer is empty right after the flush, so the space test always
      // passes here. ARM therefore loads the first burst itself and goes
      // straight to FETCH.
      S_ARM: begin
        state_n = (FRAME_WORDS == 0) ? S_WAIT : S_FETCH;
      end
      S_WAIT: begin
        if (frame_pending) begin
          pending_take = 1'b1;
          state_n      = enable ? S_ARM : S_IDLE;
        end else if (words_left == '0) begin
          state_n = S_DONE;
        end else if (space_ok) begin
          load_burst = 1'b1;
          state_n    = S_FETCH;
        end
      end
      // A frame start seen here waits until the burst ends, so the bus is
      // never abandoned mid-handshake.
      S_FETCH: begin
        if (bus_ack && (burst_cnt == PW'(1))) state_n = S_WAIT;
      end
      S_DONE: begin
        if (frame_pending) begin
          pending_take = 1'b1;
          state_n      = enable ? S_ARM : S_IDLE;
        end
      end
      default: state_n = S_IDLE;
    endcase
  end

  assign bus_strobe = (state == S_FETCH);
  assign bus_addr   = addr;

  // ---------------------------------------------------------------------------
  // State, pointers, and fetch counters
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= S_IDLE;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      addr       <= '0;
      words_left <= '0;
      burst_cnt  <= '0;
      underrun   <= 1'b0;
      out_word   <= '0;
    end else begin
      state <= state_n;
      if (state == S_ARM) begin
        wr_ptr     <= '0;
        rd_ptr     <= '0;
        addr       <= base_addr;
        words_left <= WL_W'(FRAME_WORDS);
        burst_cnt  <= PW'(FIRST_BURST);
        underrun   <= 1'b0;
      end else begin
        if (load_burst) burst_cnt <= PW'(need32);
        if (wr_en) begin
          wr_ptr     <= wr_ptr + PW'(1);
          addr       <= addr + ADDR_BITS'(1);
          words_left <= words_left - WL_W'(1);
          burst_cnt  <= burst_cnt - PW'(1);
        end
        if (pop)       rd_ptr   <= rd_ptr + PW'(1);
        if (empty_pop) underrun <= 1'b1;
      end
      // The head copy trails any pointer change by one clock. It holds its
      // last value while the FIFO is empty.
      if (!fifo_empty) out_word <= mem[rd_ptr[FIFO_LOG2-1:0]];
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr[FIFO_LOG2-1:0]] <= bus_data;
  end

  assign red_byte    = out_word[7:0];
  assign green_byte  = out_word[15:8];
  assign blue_byte   = out_word[23:16];
  assign bright_byte = out_word[31:24];

`ifdef VIDEO_FETCH_UNDERRUN_CNT_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      underrun_cnt <= '0;
    end else if (empty_pop && (underrun_cnt != 16'hFFFF)) begin
      underrun_cnt <= underrun_cnt + 16'd1;
    end
  end
`endif

  assign dbg_state = state;
  assign dbg_level = level;

  a_no_write_on_full: assert property (@(posedge clk) disable iff (reset)
    !(wr_en && fifo_full));

endmodule

// File: tb/tb_video_fetch_sequencer.sv
// Self-checking bench for video_fetch_sequencer (small frame for run time).
module tb_video_fetch_sequencer;

  localparam int AW = 30;
  localparam int L  = 5;
  localparam int FW = 100;   // 12 full bursts plus a final burst of 4

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_ARM   = 3'd1;
  localparam logic [2:0] ST_FETCH = 3'd2;
  localparam logic [2:0] ST_WAIT  = 3'd3;
  localparam logic [2:0] ST_DONE  = 3'd4;

  logic          clk = 1'b0;
  logic          reset, enable, vga_vsync, rd, bus_ack, bus_strobe, underrun;
  logic [AW-1:0] base_addr, bus_addr;
  logic [31:0]   bus_data;
  logic [7:0]    red_byte, green_byte, blue_byte, bright_byte;
  logic [2:0]    dbg_state;
  logic [L:0]    dbg_level;
`ifdef VIDEO_FETCH_UNDERRUN_CNT_EN
  logic [15:0]   underrun_cnt;
`endif

  video_fetch_sequencer #(.ADDR_BITS(AW), .FIFO_LOG2(L), .BURST_LEN(8), .FRAME_WORDS(FW)) dut (
    .clk(clk), .reset(reset), .enable(enable), .base_addr(base_addr),
    .vga_vsync(vga_vsync), .rd(rd), .bus_addr(bus_addr), .bus_strobe(bus_strobe),
    .bus_ack(bus_ack), .bus_data(bus_data), .red_byte(red_byte),
    .green_byte(green_byte), .blue_byte(blue_byte), .bright_byte(bright_byte),
    .underrun(underrun),
`ifdef VIDEO_FETCH_UNDERRUN_CNT_EN
    .underrun_cnt(underrun_cnt),
`endif
    .dbg_state(dbg_state), .dbg_level(dbg_level)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- scoreboard state ----------------
  int checks = 0;
  int errors = 0;
  int ack_total = 0;
  logic ack_en;
  logic [30:0] exp_q[$];   // bit 30 marks the first word of a frame
  logic [31:0] mdl_q[$];   // words the FIFO should hold, oldest first

  // Memory contents seen by the sequencer: a fixed pattern of the address.
  function automatic logic [31:0] data_of(input logic [AW-1:0] a);
    return {a[7:0] ^ 8'hB0, ~a[7:0], a[15:8], a[7:0] + 8'd3};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wait_state(input logic [2:0] st, input int limit, input string name, output int n);
    n = 0;
    while (dbg_state !== st && n < limit) begin
      tick(1);
      n++;
    end
    if (dbg_state !== st) begin
      checks++;
      errors++;
      $display("FAIL timeout_%s: state %0d expected %0d", name, dbg_state, st);
    end
  endtask

  task automatic push_frame(input logic [AW-1:0] base, input int n);
    for (int i = 0; i < n; i++) exp_q.push_back({(i == 0), base + AW'(i)});
  endtask

  task automatic pop_once();
    rd = 1'b1;
    tick(1);
    rd = 1'b0;
    tick(7);
  endtask

  // ---------------- bus responder (memory model) ----------------
  initial begin
    bus_ack  = 1'b0;
    bus_data = '0;
    forever begin
      @(posedge clk);
      #2;
      bus_ack  = bus_strobe && ack_en;
      bus_data = data_of(bus_addr);
    end
  end

  // ---------------- monitor ----------------
  logic [30:0] mon_e;
  logic [31:0] mon_w;
  initial begin
    forever begin
      @(negedge clk);
      if (!reset) begin
        // A pop is evaluated before a same-cycle write, as in the FIFO.
        if (rd && mdl_q.size() > 0) begin
          mon_w = mdl_q.pop_front();
          check("head_word", {bright_byte, blue_byte, green_byte, red_byte}, mon_w);
        end
        if (bus_ack) begin
          ack_total++;
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL addr_unexpected: got 0x%0h expected none", bus_addr);
          end else begin
            mon_e = exp_q.pop_front();
            if (mon_e[30]) mdl_q.delete();
            check("bus_addr", 32'(bus_addr), 32'(mon_e[29:0]));
            mdl_q.push_back(data_of(mon_e[29:0]));
          end
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  int n, a0;
  logic [31:0] w_old;
  initial begin
    reset = 1'b1; enable = 1'b0; vga_vsync = 1'b1; rd = 1'b0;
    base_addr = '0; ack_en = 1'b1;
    tick(3);
    reset = 1'b0;

    // Reset state
    check("rst_strobe", bus_strobe, 0);
    check("rst_addr", 32'(bus_addr), 0);
    check("rst_bytes", {bright_byte, blue_byte, green_byte, red_byte}, 0);
    check("rst_underrun", underrun, 0);
    check("rst_state", dbg_state, ST_IDLE);
    check("rst_level", dbg_level, 0);
`ifdef VIDEO_FETCH_UNDERRUN_CNT_EN
    check("rst_ucnt", underrun_cnt, 0);
`endif

    // Steady state: first frame at 0x1000, ack every cycle
    enable = 1'b1;
    base_addr = 30'h1000;
    push_frame(30'h1000, FW);
    vga_vsync = 1'b0;
    wait_state(ST_ARM, 10, "arm1", n);
    checks++;
    if (n < 3 || n > 4) begin
      errors++;
      $display("FAIL vsync_latency: got %0d expected 3..4", n);
    end
    vga_vsync = 1'b1;
    tick(1);
    check("first_strobe", bus_strobe, 1);
    check("first_addr", 32'(bus_addr), 32'h1000);
    n = 0;
    while (bus_strobe && n < 20) begin
      n++;
      tick(1);
    end
    check("burst_len", n, 8);
    tick(40);
    check("fill_level", dbg_level, 32);
    check("fill_state", dbg_state, ST_WAIT);
    check("fill_strobe", bus_strobe, 0);

    // Continuous frame: pop every 8 clocks until the whole frame is consumed
    for (int i = 0; i < FW; i++) pop_once();
    check("frame_acks", ack_total, FW);
    check("frame_exp_left", exp_q.size(), 0);
    check("frame_done", dbg_state, ST_DONE);
    check("frame_underrun", underrun, 0);
    check("frame_level", dbg_level, 0);

    // Frame start mid-burst: hold the first burst with 3 words outstanding
    ack_en = 1'b0;
    base_addr = 30'h2000;
    push_frame(30'h2000, 8);
    push_frame(30'h3000, FW);
    vga_vsync = 1'b0;
    wait_state(ST_ARM, 10, "arm2", n);
    vga_vsync = 1'b1;
    tick(1);
    check("mid_first_addr", 32'(bus_addr), 32'h2000);
    base_addr = 30'h3000;
    a0 = ack_total;
    ack_en = 1'b1;
    tick(5);
    ack_en = 1'b0;
    vga_vsync = 1'b0;
    tick(8);
    vga_vsync = 1'b1;
    check("mid_fetch_holds", dbg_state, ST_FETCH);
    check("mid_level5", dbg_level, 5);
    ack_en = 1'b1;
    wait_state(ST_ARM, 12, "arm3", n);
    check("mid_burst_acks", ack_total - a0, 8);
    tick(1);
    check("mid_flushed", dbg_level, 0);
    check("mid_new_strobe", bus_strobe, 1);
    check("mid_new_addr", 32'(bus_addr), 32'h3000);

    // Underrun: stall the bus and pop 32 valid words plus 5 on empty
    tick(40);
    check("ur_fill", dbg_level, 32);
    ack_en = 1'b0;
    for (int i = 0; i < 37; i++) begin
      pop_once();
      if (i == 31) check("ur_not_yet", underrun, 0);
    end
    check("ur_flag", underrun, 1);
    check("ur_level", dbg_level, 0);
`ifdef VIDEO_FETCH_UNDERRUN_CNT_EN
    check("ur_count", underrun_cnt, 5);
`endif
    ack_en = 1'b1;
    tick(50);
    check("ur_refill", dbg_level, 32);

    // Simultaneous write and pop at occupancy 31
    ack_en = 1'b0;
    for (int i = 0; i < 8; i++) pop_once();
    check("sim_level24", dbg_level, 24);
    check("sim_fetch", dbg_state, ST_FETCH);
    ack_en = 1'b1;
    tick(7);
    check("sim_level31", dbg_level, 31);
    w_old = mdl_q[0];
    rd = 1'b1;
    tick(1);
    rd = 1'b0;
    check("sim_level_kept", dbg_level, 31);
    check("sim_burst_end", dbg_state, ST_WAIT);
    check("sim_head_lag", {bright_byte, blue_byte, green_byte, red_byte}, w_old);
    tick(1);
    check("sim_head_next", {bright_byte, blue_byte, green_byte, red_byte}, mdl_q[0]);

    // Disable mid-frame: the frame still completes, the next vsync idles
    enable = 1'b0;
    n = 0;
    while (dbg_state !== ST_DONE && n < 100) begin
      pop_once();
      n++;
    end
    n = 0;
    while (mdl_q.size() > 0 && n < 40) begin
      pop_once();
      n++;
    end
    check("dis_done", dbg_state, ST_DONE);
    check("dis_exp_left", exp_q.size(), 0);
    check("dis_level", dbg_level, 0);
    vga_vsync = 1'b0;
    tick(8);
    vga_vsync = 1'b1;
    check("dis_idle", dbg_state, ST_IDLE);
    n = 0;
    for (int i = 0; i < 20; i++) begin
      if (bus_strobe) n++;
      tick(1);
    end
    check("dis_no_strobe", n, 0);

    // Re-enable: frame start clears the sticky underrun flag
    enable = 1'b1;
    base_addr = 30'h4000;
    push_frame(30'h4000, FW);
    vga_vsync = 1'b0;
    wait_state(ST_ARM, 10, "arm4", n);
    vga_vsync = 1'b1;
    tick(1);
    check("re_underrun_clr", underrun, 0);
    check("re_addr", 32'(bus_addr), 32'h4000);
    tick(20);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Hard stop in case a bounded loop is somehow bypassed.
  initial begin
    #400000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

endmodule
